// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX path: arbiter state encoding, header base
// and the registered FIFO write beat.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HEADER   = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_CHECKSUM = 2'd3
    } tx_state_e;

    localparam logic [7:0]  HDR_BASE_DEFAULT = 8'hA0;
    localparam int unsigned STATUS_W         = 16;
    localparam int unsigned FIFO_FULL_BIT    = 8;

    typedef struct packed {
        logic       write;
        logic [7:0] data;
    } fifo_wr_t;

    // Header byte carries the requester index in its low three bits.
    function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [2:0] idx);
        return base | {5'b0, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    logic [PW-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = PW'((32'(ptr) + off) % NREQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packetising round-robin arbiter in front of a UART TX FIFO: emits
// header, payload bytes and an XOR checksum, one FIFO write at most every other cycle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_LEN  = 16,
    parameter logic [7:0]  HDR_BASE = HDR_BASE_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    input  logic [STATUS_W-1:0] fifo_status,
    output logic [7:0]          fifo_data,
    output logic                fifo_write,
    output logic [NREQ-1:0]     grant,
    output logic                busy
);

    localparam int unsigned PW = $clog2(NREQ);

    tx_state_e     state_q, state_nxt;
    logic [PW-1:0] ptr_q, ptr_nxt;
    logic [PW-1:0] gidx_q, gidx_nxt;
    logic [NREQ-1:0] grant_q, grant_nxt;
    logic [7:0]    chk_q, chk_nxt;
    logic [7:0]    cnt_q, cnt_nxt;
    fifo_wr_t      wr_q, wr_nxt;
    logic          busy_q;

    logic          arb_any;
    logic [PW-1:0] arb_idx;
    logic          can_write;
    logic          cur_valid;
    logic          cur_last;
    logic [7:0]    cur_data;
    logic          accept;
    logic [7:0]    cnt_inc;
    logic          pkt_end;
    logic          unused_status;

    assign unused_status = ^{fifo_status[STATUS_W-1:FIFO_FULL_BIT+1], fifo_status[FIFO_FULL_BIT-1:0]};

    assign fifo_write = wr_q.write;
    assign fifo_data  = wr_q.data;
    assign grant      = grant_q;
    assign busy       = busy_q;

    // The registered strobe blocks the cycle after a write so FIFO status can settle.
    assign can_write = ~fifo_status[FIFO_FULL_BIT] & ~wr_q.write;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .any (arb_any),
        .idx (arb_idx)
    );

    // Select the granted requester's byte lane.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = 8'h00;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gidx_q == PW'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[8*i +: 8];
            end
        end
    end

    assign accept  = (state_q == ST_PAYLOAD) & can_write & cur_valid;
    assign cnt_inc = cnt_q + 8'd1;
    assign pkt_end = cur_last | (cnt_inc == 8'(MAX_LEN));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:     if (arb_any)            state_nxt = ST_HEADER;
            ST_HEADER:   if (can_write)          state_nxt = ST_PAYLOAD;
            ST_PAYLOAD:  if (accept && pkt_end)  state_nxt = ST_CHECKSUM;
            ST_CHECKSUM: if (can_write)          state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        ptr_nxt   = ptr_q;
        gidx_nxt  = gidx_q;
        grant_nxt = grant_q;
        chk_nxt   = chk_q;
        cnt_nxt   = cnt_q;
        wr_nxt    = '{write: 1'b0, data: wr_q.data};
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gidx_nxt  = arb_idx;
                    grant_nxt = NREQ'(1) << arb_idx;
                    ptr_nxt   = (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + PW'(1);
                end
            end
            ST_HEADER: begin
                if (can_write) begin
                    wr_nxt  = '{write: 1'b1, data: hdr_byte(HDR_BASE, 3'(gidx_q))};
                    chk_nxt = 8'h00;
                    cnt_nxt = 8'h00;
                end
            end
            ST_PAYLOAD: begin
                if (can_write) req_ready = grant_q;
                if (accept) begin
                    wr_nxt  = '{write: 1'b1, data: cur_data};
                    chk_nxt = chk_q ^ cur_data;
                    cnt_nxt = cnt_inc;
                end
            end
            ST_CHECKSUM: begin
                if (can_write) begin
                    wr_nxt    = '{write: 1'b1, data: chk_q};
                    grant_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            chk_q   <= 8'h00;
            cnt_q   <= 8'h00;
            wr_q    <= '{write: 1'b0, data: 8'h00};
            busy_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_nxt;
            gidx_q  <= gidx_nxt;
            grant_q <= grant_nxt;
            chk_q   <= chk_nxt;
            cnt_q   <= cnt_nxt;
            wr_q    <= wr_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte streams in,
// expected FIFO byte sequence queued and checked by an independent monitor.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned MAX_LEN = 16;
    localparam logic [7:0]  HDR     = 8'hA0;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [NREQ-1:0]     req_valid = '0;
    logic [8*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]     req_last = '0;
    logic [NREQ-1:0]     req_ready;
    logic [15:0]         fifo_status;
    logic [7:0]          fifo_data;
    logic                fifo_write;
    logic [NREQ-1:0]     grant;
    logic                busy;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .HDR_BASE(HDR)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_status (fifo_status),
        .fifo_data   (fifo_data),
        .fifo_write  (fifo_write),
        .grant       (grant),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int nwr    = 0;
    int last_wr = -100;
    logic stall_prev = 1'b0;
    logic [7:0] exp_q[$];
    int wr_log[$];
    logic [8:0] stim [NREQ][64];
    int head [NREQ];
    int tail [NREQ];
    logic [NREQ-1:0] hs = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input int r, input int n, input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            stim[r][tail[r]] = {(i == n-1), 8'(int'(base) + int'(step) * i)};
            tail[r]++;
        end
    endtask

    // Expected FIFO bytes for a stream, split into MAX_LEN chunks.
    task automatic expect_stream(input int r, input int n, input logic [7:0] base, input logic [7:0] step);
        int done;
        int len;
        logic [7:0] c;
        logic [7:0] b;
        done = 0;
        while (done < n) begin
            len = (n - done > int'(MAX_LEN)) ? int'(MAX_LEN) : n - done;
            c = 8'h00;
            exp_q.push_back(HDR | 8'(r));
            for (int i = 0; i < len; i++) begin
                b = 8'(int'(base) + int'(step) * (done + i));
                exp_q.push_back(b);
                c = c ^ b;
            end
            exp_q.push_back(c);
            done += len;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < budget) begin
            @(negedge CLK);
            i++;
        end
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_drain_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int i;
        i = 0;
        while (nwr < target && i < budget) begin
            @(negedge CLK);
            #1;
            i++;
        end
        check("write_wait", 32'(nwr >= target), 32'd1);
    endtask

    task automatic flush_stim();
        for (int r = 0; r < int'(NREQ); r++) head[r] = tail[r];
    endtask

    // Requester model: present the head byte, advance after a handshake.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            for (int r = 0; r < int'(NREQ); r++) begin
                if (hs[r]) head[r]++;
                if (head[r] < tail[r]) begin
                    req_valid[r]         = 1'b1;
                    req_data[8*r +: 8]   = stim[r][head[r]][7:0];
                    req_last[r]          = stim[r][head[r]][8];
                end else begin
                    req_valid[r] = 1'b0;
                    req_last[r]  = 1'b0;
                end
            end
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each FIFO write.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            cyc++;
            hs = req_valid & req_ready;
            if (RST_N === 1'b1) begin
                check("ready_only_granted", 32'(req_ready & ~grant), 32'd0);
                check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                check("busy_vs_grant", 32'(busy), 32'(|grant));
                if (fifo_status[8]) check("ready_during_full", 32'(req_ready), 32'd0);
                if (stall_prev) check("write_after_full", 32'(fifo_write), 32'd0);
                if (fifo_write) begin
                    check("write_spacing", 32'(cyc - last_wr >= 2), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {24'd0, fifo_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("fifo_byte", {24'd0, fifo_data}, {24'd0, e});
                    end
                    wr_log.push_back(cyc);
                    last_wr = cyc;
                    nwr++;
                end
            end
            stall_prev = fifo_status[8];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n1;
        RST_N       = 1'b0;
        fifo_status = 16'h0000;
        #12;
        check("rst_fifo_write", 32'(fifo_write), 32'd0);
        check("rst_fifo_data", {24'd0, fifo_data}, 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Single requester 1: A1,11,22,33,00 every two cycles.
        wr_log.delete();
        send(1, 3, 8'h11, 8'h11);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h00);
        for (int i = 0; i < 20 && grant == '0; i++) @(negedge CLK);
        check("t1_grant", 32'(grant), 32'h2);
        check("t1_busy", 32'(busy), 32'd1);
        wait_drain("t1", 200);
        check("t1_write_count", 32'(wr_log.size()), 32'd5);
        if (wr_log.size() == 5) check("t1_span", 32'(wr_log[4] - wr_log[0]), 32'd8);

        // Requesters 0 and 2 valid straight out of reset.
        @(posedge CLK); #2;
        RST_N = 1'b0;
        flush_stim();
        send(0, 1, 8'h5A, 8'h00);
        send(2, 1, 8'h5A, 8'h00);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wait_drain("t2", 200);
        repeat (2) @(negedge CLK);
        // Pointer now at 3: requester 3 wins over requester 0.
        send(0, 1, 8'h01, 8'h00);
        send(3, 1, 8'h02, 8'h00);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h02); exp_q.push_back(8'h02);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        wait_drain("t2_ptr", 200);

        // 20-byte stream truncated into 16 + 4.
        send(3, 20, 8'h30, 8'h01);
        expect_stream(3, 20, 8'h30, 8'h01);
        wait_drain("t3", 400);

        // FIFO full for 10 cycles mid-payload; unrelated status bits toggle.
        fifo_status = 16'hFE7F;
        send(2, 6, 8'h40, 8'h01);
        expect_stream(2, 6, 8'h40, 8'h01);
        wait_writes(nwr + 3, 100);
        @(posedge CLK); #1;
        fifo_status = 16'h01A5;
        @(negedge CLK); #1;
        n0 = nwr;
        repeat (9) @(negedge CLK);
        #1;
        n1 = nwr;
        check("t4_no_write_in_stall", 32'(n1), 32'(n0));
        @(posedge CLK); #1;
        fifo_status = 16'h7E3C;
        wait_drain("t4", 200);
        fifo_status = 16'h0000;

        // Reset after header and two payload bytes: packet abandoned.
        send(1, 5, 8'h71, 8'h01);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h71); exp_q.push_back(8'h72);
        wait_writes(nwr + 3, 100);
        #1;
        RST_N = 1'b0;
        #1;
        check("t5_rst_fifo_write", 32'(fifo_write), 32'd0);
        check("t5_rst_fifo_data", {24'd0, fifo_data}, 32'd0);
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_partial_seen", 32'(exp_q.size()), 32'd0);
        flush_stim();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);
        check("t5_idle_after_rst", 32'(busy), 32'd0);
        send(1, 1, 8'h81, 8'h00);
        send(0, 1, 8'h80, 8'h00);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h80); exp_q.push_back(8'h80);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h81); exp_q.push_back(8'h81);
        wait_drain("t5", 200);

        repeat (4) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
